// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache in front of the
// memory controller fetch port; single outstanding miss, rollback-safe.
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_rollback,
  input  logic        in_fetch_ena,
  input  logic [31:0] in_fetch_addr,
  output logic        out_inst_ok,
  output logic [31:0] out_inst,
  output logic        out_mem_ena,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ok,
  input  logic [31:0] in_mem_data
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS_WAIT
  } state_t;

  state_t state;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];
  logic [31:2]         pend_q;

  logic [INDEX_BITS-1:0] f_idx;
  logic [INDEX_BITS-1:0] p_idx;
  logic [TAG_BITS-1:0]   f_tag;
  logic [TAG_BITS-1:0]   p_tag;
  logic                  hit;
  logic                  fill;

  assign f_idx = in_fetch_addr[INDEX_BITS+1:2];
  assign f_tag = in_fetch_addr[31:INDEX_BITS+2];
  assign p_idx = pend_q[INDEX_BITS+1:2];
  assign p_tag = pend_q[31:INDEX_BITS+2];
  assign hit   = valid[f_idx] && (tag_q[f_idx] == f_tag);

  // An in-flight fill still lands even when a rollback cancels the miss.
  assign fill  = rdy && (state == MISS_WAIT) && in_mem_ok;

  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      data_q[p_idx] <= in_mem_data;
      tag_q[p_idx]  <= p_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      pend_q       <= '0;
      out_inst_ok  <= 1'b0;
      out_inst     <= '0;
      out_mem_ena  <= 1'b0;
      out_mem_addr <= '0;
    end else begin
      out_inst_ok <= 1'b0;
      out_mem_ena <= 1'b0;
      if (fill) begin
        valid[p_idx] <= 1'b1;
      end
      if (rdy) begin
        if (in_rollback) begin
          state <= IDLE;
        end else begin
          unique case (state)
            IDLE: begin
              if (in_fetch_ena) begin
                if (hit) begin
                  out_inst_ok <= 1'b1;
                  out_inst    <= data_q[f_idx];
                end else begin
                  pend_q       <= in_fetch_addr[31:2];
                  out_mem_ena  <= 1'b1;
                  out_mem_addr <= in_fetch_addr & 32'hFFFF_FFFC;
                  state        <= MISS_WAIT;
                end
              end
            end
            MISS_WAIT: begin
              if (in_mem_ok) begin
                out_inst_ok <= 1'b1;
                out_inst    <= in_mem_data;
                state       <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, word-granular instruction cache between the instruction fetcher and the memory controller's fetch port.
- Answers fetch requests from its own storage on a hit.
- On a miss, issues a single 4-byte read to the memory controller, fills the line and returns the word.
- Honours misbranch rollback by cancelling any outstanding miss without corrupting cache contents.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines, one 32-bit word per line).
- TAG_BITS, 32-INDEX_BITS-2, tag width; addr[1:0] ignored (word aligned).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = freeze
- in_rollback  in  1  misbranch flush
- in_fetch_ena  in  1  fetch request strobe, one cycle
- in_fetch_addr  in  32  fetch PC
- out_inst_ok  out  1  one-cycle pulse, out_inst valid
- out_inst  out  32  instruction word
- out_mem_ena  out  1  one-cycle request pulse to memory controller fetch port
- out_mem_addr  out  32  word-aligned miss address
- in_mem_ok  in  1  one-cycle fill-complete pulse from memory controller
- in_mem_data  in  32  fill word, valid with in_mem_ok

Behaviour:
- Reset (rst=1 at posedge):
  - all valid bits cleared; state=IDLE.
  - out_inst_ok=0, out_mem_ena=0, out_inst=0, out_mem_addr=0.
  - Reset overrides rollback and rdy.
- Default every cycle: out_inst_ok<=0, out_mem_ena<=0 (pulses).
- rdy=0: no state, valid, tag or data change; pulses deassert; in_fetch_ena and in_mem_ok ignored.
  - The memory controller does not pulse ok while rdy=0.
- Address split: index=addr[INDEX_BITS+1:2], tag=addr[31:INDEX_BITS+2].
- States: IDLE, MISS_WAIT.
- IDLE with in_fetch_ena=1:
  - Hit (valid[index] && tag match): next cycle out_inst_ok=1, out_inst=data[index]. Latency 1. State stays IDLE.
  - Miss: latch addr into pending_addr. Next cycle out_mem_ena=1 for exactly one cycle, out_mem_addr={addr[31:2],2'b00}. State -> MISS_WAIT.
- MISS_WAIT:
  - in_fetch_ena ignored; the fetcher keeps at most one request outstanding.
  - On in_mem_ok: write data[pidx]<=in_mem_data, tag[pidx]<=ptag, valid[pidx]<=1.
  - Next cycle out_inst_ok=1, out_inst=in_mem_data. State -> IDLE.
  - Miss latency: request cycle t, out_mem_ena at t+1, out_inst_ok one cycle after in_mem_ok.
- Rollback (in_rollback=1, rdy=1):
  - state -> IDLE; out_inst_ok, out_mem_ena forced 0 that cycle; in_fetch_ena same cycle ignored.
  - Valid/tag/data arrays kept; no flush.
  - The memory controller drops its pending fetch on rollback, so no in_mem_ok for the cancelled miss is awaited.
- in_mem_ok in same cycle as rollback (already in flight): line still filled (data correct for that address); no out_inst_ok.
- in_mem_ok while IDLE (stale, after rollback): ignored, no fill, no pulse.
- Request in cycle immediately after out_inst_ok: accepted normally. Back-to-back hits give one result per cycle.
- Fill and hit to the same index never overlap, since a miss blocks new requests.
- Index conflict: a new fill overwrites the line unconditionally (direct mapped).
- Address 0xFFFFFFFC legal; no wrap special case.

Test Plan:
- Reset, then fetch 0x00000000 -> miss: out_mem_ena=1, out_mem_addr=0x0 at t+1. Drive in_mem_ok, data 0x00000013 -> out_inst_ok=1, out_inst=0x00000013 next cycle.
- Refetch 0x00000000 -> hit: out_inst_ok=1 at t+1, out_inst=0x00000013, out_mem_ena stays 0. Three back-to-back hits give 3 consecutive ok pulses.
- Conflict: fill 0x00000004=0xAAAA0001, then fetch 0x00000104 (same index, INDEX_BITS=6) -> miss, fill 0xBBBB0002. Fetch 0x00000004 again -> miss.
- Fetch miss 0x00000040, rollback two cycles later -> IDLE, no out_inst_ok. New fetch 0x00000000 (cached) -> hit at t+1. Stray in_mem_ok afterward -> ignored, no pulse, no fill.
- Rollback coincident with in_mem_ok for 0x00000080, data 0x12345678 -> no out_inst_ok. Later fetch 0x00000080 -> hit returning 0x12345678.
- rdy=0 during MISS_WAIT with fetch strobes -> no change. rdy=1, in_mem_ok -> normal completion. rst mid-miss -> all lines invalid, outputs 0.
